// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: opcodes, sequencer states and IR field positions.
// MUL/DIV support is compiled in only when CTRL_MULDIV_EN is defined.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_ADD = 5'b01010;
    localparam logic [4:0] OP_SUB = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;

    localparam int OPCODE_MSB = 31;
    localparam int RA_MSB     = 26;
    localparam int RB_MSB     = 22;
    localparam int RC_MSB     = 18;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
`ifdef CTRL_MULDIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic is_supported(input logic [4:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || is_muldiv(op);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register field to one-hot select; all zero when disabled or out of range.
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && (32'(sel) < NUM_REGS)) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-step control unit for the add/sub datapath (fetch, decode, execute).
// Define CTRL_MULDIV_EN to build MUL/DIV support with the extra T6 step.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run,
    input  logic                Mem_ready,
    input  logic [31:0]         IR,
    output logic                PCout,
    output logic                ZLowout,
    output logic                ZHighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowIn,
    output logic                ZHighIn,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [OPW-1:0]      op_code,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                Done,
    output logic                Illegal,
    output state_t              state_dbg
);

    state_t     state, state_nxt;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       supported, muldiv;
    logic       rin_en, rout_en;
    logic [3:0] rout_sel;
    logic       illegal_q;
    logic       unused_ir;

    assign opcode    = IR[OPCODE_MSB -: 5];
    assign ra        = IR[RA_MSB -: 4];
    assign rb        = IR[RB_MSB -: 4];
    assign rc        = IR[RC_MSB -: 4];
    assign unused_ir = ^IR[14:0];
    assign supported = is_supported(opcode);
    assign muldiv    = is_muldiv(opcode);
    assign state_dbg = state;
    assign Illegal   = illegal_q;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_T3 && !supported) illegal_q <= 1'b1;
        end
    end

    // Mem_ready qualifies read data; the sequencer only looks at it while waiting in T1/T1W.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Run) state_nxt = S_T0;
            S_T0:    state_nxt = S_T1;
            S_T1:    state_nxt = Mem_ready ? S_T2 : S_T1W;
            S_T1W:   if (Mem_ready) state_nxt = S_T2;
            S_T2:    state_nxt = S_T3;
            S_T3:    state_nxt = supported ? S_T4 : S_HALT;
            S_T4:    state_nxt = S_T5;
`ifdef CTRL_MULDIV_EN
            S_T5:    state_nxt = muldiv ? S_T6 : (Run ? S_T0 : S_IDLE);
            S_T6:    state_nxt = Run ? S_T0 : S_IDLE;
`else
            S_T5:    state_nxt = Run ? S_T0 : S_IDLE;
`endif
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        ZLowout  = 1'b0;
        ZHighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Done     = 1'b0;
        op_code  = '0;
        case (state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            S_T1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: Yin = supported;
            S_T4: begin
                op_code = OPW'(opcode);
                ZLowIn  = 1'b1;
`ifdef CTRL_MULDIV_EN
                ZHighIn = muldiv;
`endif
            end
            S_T5: begin
                ZLowout = 1'b1;
`ifdef CTRL_MULDIV_EN
                LOin    = muldiv;
`endif
                Done    = !muldiv;
            end
`ifdef CTRL_MULDIV_EN
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign rout_en  = (state == S_T3 && supported) || (state == S_T4);
    assign rout_sel = (state == S_T3) ? rb : rc;
    assign rin_en   = (state == S_T5) && !muldiv;

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .sel    (ra),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed table, hand-written corner sequences and a
// randomized run against a per-instruction schedule model. Honours CTRL_MULDIV_EN.
module tb_control_sequencer;

    typedef struct packed {
        logic        pcout, zlowout, zhighout, mdrout, marin, pcin, mdrin, irin, yin;
        logic        zlowin, zhighin, hiin, loin, incpc, read, done, illegal;
        logic [4:0]  op;
        logic [15:0] rin, rout;
    } strobes_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        int          exp_cycle;
        logic        exp_illegal;
        logic [15:0] exp_rin;
    } vec_t;

`ifdef CTRL_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Clear, Run, Mem_ready;
    logic [31:0] IR;
    logic        PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin;
    logic        ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Done, Illegal;
    logic [4:0]  op_code;
    logic [15:0] Rin, Rout;
    cpu_ctrl_pkg::state_t state_dbg;
    strobes_t    act;

    int errors = 0;
    int checks = 0;
    strobes_t exp_q[$];
    logic     mr_q[$];

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .op_code(op_code), .Rin(Rin), .Rout(Rout),
        .Done(Done), .Illegal(Illegal), .state_dbg(state_dbg)
    );

    always #5 Clock = ~Clock;

    assign act = {PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                  ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Done, Illegal,
                  op_code, Rin, Rout};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected per-cycle strobes of one instruction, derived from the step rules.
    function automatic bit build(input logic [31:0] ir, input int waits);
        logic [4:0] op;
        bit md, ok;
        strobes_t s;
        op = ir[31:27];
        md = MULDIV_EN && (op == 5'b01110 || op == 5'b01111);
        ok = md || op == 5'b00101 || op == 5'b00110 || op == 5'b01010 || op == 5'b01011;
        exp_q.delete();
        mr_q.delete();
        s = '0; s.pcout = 1; s.marin = 1; s.incpc = 1; s.zlowin = 1;
        exp_q.push_back(s); mr_q.push_back(1'($urandom_range(0, 1)));
        s = '0; s.zlowout = 1; s.pcin = 1; s.read = 1; s.mdrin = 1;
        exp_q.push_back(s); mr_q.push_back(waits == 0);
        for (int j = 0; j < waits; j++) begin
            s = '0; s.read = 1; s.mdrin = 1;
            exp_q.push_back(s); mr_q.push_back(j == waits - 1);
        end
        s = '0; s.mdrout = 1; s.irin = 1;
        exp_q.push_back(s); mr_q.push_back(1'($urandom_range(0, 1)));
        s = '0;
        if (ok) begin s.rout = 16'(1) << ir[22:19]; s.yin = 1; end
        exp_q.push_back(s); mr_q.push_back(1'($urandom_range(0, 1)));
        if (!ok) return 1'b1;
        s = '0; s.rout = 16'(1) << ir[18:15]; s.op = op; s.zlowin = 1; s.zhighin = md;
        exp_q.push_back(s); mr_q.push_back(1'($urandom_range(0, 1)));
        s = '0; s.zlowout = 1;
        if (md) s.loin = 1; else begin s.rin = 16'(1) << ir[26:23]; s.done = 1; end
        exp_q.push_back(s); mr_q.push_back(1'($urandom_range(0, 1)));
        if (md) begin
            s = '0; s.zhighout = 1; s.hiin = 1; s.done = 1;
            exp_q.push_back(s); mr_q.push_back(1'($urandom_range(0, 1)));
        end
        return 1'b0;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the last step of the instruction.
    task automatic run_model(input logic [31:0] ir, input int waits, input logic run_lvl,
                             output bit ill);
        strobes_t e;
        ill = build(ir, waits);
        IR  = ir;
        Run = run_lvl;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            Mem_ready = mr_q.pop_front();
            @(negedge Clock);
            check("model_step", 64'(act), 64'(e));
            @(posedge Clock); #1;
        end
    endtask

    task automatic do_clear();
        @(posedge Clock); #1;
        Clear = 1'b0;
        #2;
        Clear = 1'b1;
    endtask

    // One IDLE cycle with Run high so the next edge enters T0.
    task automatic idle_start();
        Run = 1'b1;
        @(negedge Clock);
        check("idle_quiet", 64'(act), 64'(0));
        @(posedge Clock); #1;
    endtask

    vec_t     tbl[8];
    strobes_t s;
    int       got_cycle, pc_cnt, rd_cnt, d1, d2, lim;
    logic     got_ill;
    logic [15:0] got_rin;
    logic [31:0] rnd, ir;
    logic [4:0]  op;
    bit          ill;

    initial begin
        tbl[0] = '{32'h5A918000, 0, 6, 1'b0, 16'h0020};
        tbl[1] = '{32'h5A918000, 3, 9, 1'b0, 16'h0020};
        tbl[2] = '{32'h50000000, 0, 6, 1'b0, 16'h0001};
        tbl[3] = '{32'h2F800000, 0, 6, 1'b0, 16'h8000};
        tbl[4] = '{32'h33800000, 1, 7, 1'b0, 16'h0080};
        tbl[5] = '{32'hF8000000, 0, 5, 1'b1, 16'h0000};
        tbl[6] = MULDIV_EN ? '{32'h70800000, 0, 7, 1'b0, 16'h0000}
                           : '{32'h70800000, 0, 5, 1'b1, 16'h0000};
        tbl[7] = MULDIV_EN ? '{32'h7C800000, 2, 9, 1'b0, 16'h0000}
                           : '{32'h7C800000, 2, 7, 1'b1, 16'h0000};

        Clear = 1'b0; Run = 1'b0; Mem_ready = 1'b0; IR = '0;
        #12;
        check("reset_outputs", 64'(act), 64'(0));
        check("reset_illegal", 64'(Illegal), 64'(0));
        Clear = 1'b1;

        // Table: Run pulsed for one cycle, record first Done/Illegal cycle (T0 = 1).
        foreach (tbl[k]) begin
            do_clear();
            idle_start();
            Run = 1'b0;
            IR  = tbl[k].ir;
            got_cycle = 0; got_ill = 1'b0; got_rin = '0;
            for (int c = 1; c <= 30; c++) begin
                Mem_ready = (c >= 2 && c < 2 + tbl[k].waits) ? 1'b0 : 1'b1;
                @(negedge Clock);
                if (Done || Illegal) begin
                    got_cycle = c; got_ill = Illegal; got_rin = Rin;
                    break;
                end
                @(posedge Clock); #1;
            end
            check("tbl_cycle", 64'(got_cycle), 64'(tbl[k].exp_cycle));
            check("tbl_illegal", 64'(got_ill), 64'(tbl[k].exp_illegal));
            check("tbl_rin", 64'(got_rin), 64'(tbl[k].exp_rin));
        end

        // SUB with one-cycle Run pulse, then IDLE.
        do_clear();
        idle_start();
        Run = 1'b0;
        IR = 32'h5A918000;
        Mem_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge Clock);
            if (c == 4) check("sub_t3", 64'({Rout, Yin, Rin}), 64'({16'h0004, 1'b1, 16'h0}));
            if (c == 5) check("sub_t4", 64'({Rout, op_code, Rin}), 64'({16'h0008, 5'b01011, 16'h0}));
            if (c == 6) check("sub_t5", 64'({Rin, Done, Rout}), 64'({16'h0020, 1'b1, 16'h0}));
            if (c == 7) check("sub_idle", 64'(act), 64'(0));
            @(posedge Clock); #1;
        end

        // Reset in the middle of T4 of an ADD, then restart.
        do_clear();
        idle_start();
        IR = 32'h50000000;
        Mem_ready = 1'b1;
        repeat (4) begin @(posedge Clock); #1; end
        @(negedge Clock);
        check("add_t4_op", 64'(op_code), 64'(5'b01010));
        #1 Clear = 1'b0;
        #1 check("async_clear", 64'(act), 64'(0));
        Clear = 1'b1;
        @(posedge Clock); #1;
        @(negedge Clock);
        s = '0; s.pcout = 1; s.marin = 1; s.incpc = 1; s.zlowin = 1;
        check("restart_t0", 64'(act), 64'(s));

        // Three wait cycles in T1.
        do_clear();
        idle_start();
        Run = 1'b0;
        IR = 32'h5A918000;
        pc_cnt = 0; rd_cnt = 0; got_cycle = 0;
        for (int c = 1; c <= 12; c++) begin
            Mem_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            @(negedge Clock);
            pc_cnt += int'(PCin);
            rd_cnt += int'(Read);
            if (Done) got_cycle = c;
            @(posedge Clock); #1;
        end
        check("wait_pcin", 64'(pc_cnt), 64'(1));
        check("wait_read", 64'(rd_cnt), 64'(4));
        check("wait_len", 64'(got_cycle), 64'(9));

        // Back-to-back ADDs with Run held.
        do_clear();
        idle_start();
        IR = 32'h50000000;
        Mem_ready = 1'b1;
        d1 = 0; d2 = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clock);
            if (Done && d1 == 0) d1 = c;
            else if (Done && d2 == 0) d2 = c;
            if (c == 7) check("b2b_t0", 64'({PCout, MARin, IncPC}), 64'(3'b111));
            @(posedge Clock); #1;
        end
        check("b2b_first", 64'(d1), 64'(6));
        check("b2b_gap", 64'(d2 - d1), 64'(6));

        // Illegal opcode: HALT ignores Run, Clear recovers.
        do_clear();
        idle_start();
        IR = 32'hF8000000;
        Mem_ready = 1'b1;
        repeat (3) begin @(posedge Clock); #1; end
        @(negedge Clock);
        check("ill_t3", 64'(act), 64'(0));
        @(posedge Clock); #1;
        s = '0; s.illegal = 1;
        for (int c = 0; c < 20; c++) begin
            Mem_ready = 1'($urandom_range(0, 1));
            @(negedge Clock);
            check("halt_quiet", 64'(act), 64'(s));
            @(posedge Clock); #1;
        end
        Clear = 1'b0;
        #1 check("halt_clear", 64'(Illegal), 64'(0));
        Clear = 1'b1;

        // Randomized instruction stream against the schedule model.
        do_clear();
        idle_start();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: op = 5'b00101;
                1: op = 5'b00110;
                2: op = 5'b01010;
                3: op = 5'b01011;
                4: op = 5'b01110;
                5: op = 5'b01111;
                default: op = 5'($urandom_range(0, 31));
            endcase
            rnd = $urandom();
            ir = {op, rnd[26:0]};
            run_model(ir, $urandom_range(0, 3), (n != 39), ill);
            if (ill) begin
                s = '0; s.illegal = 1;
                Run = 1'b1;
                repeat (3) begin
                    @(negedge Clock);
                    check("rnd_halt", 64'(act), 64'(s));
                    @(posedge Clock); #1;
                end
                if (n != 39) begin
                    do_clear();
                    idle_start();
                end
            end else if (n == 39) begin
                @(negedge Clock);
                check("rnd_end_idle", 64'(act), 64'(0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        lim = 60000;
        repeat (lim) @(posedge Clock);
        $display("FAIL timeout: got %0d cycles expected completion", lim);
        $fatal(1, "timeout");
    end

endmodule
